ascon_decrypt: RTL

ASCON_DECRYPT -- requirements
Module: ascon_decrypt

---
 rtl/ascon_decrypt.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ascon_decrypt.sv
// ASCON-style decryptor: one pre-padded AD block, 64-bit ciphertext stream, 128-bit tag check.
// Optional abort input is enabled by defining DECRYPT_ABORT_EN.

module ascon_p (
    input  logic [319:0] state_in,
    input  logic [3:0]   round_i,
    output logic [319:0] state_out
);
    logic [3:0]  rc_hi;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a2, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    always_comb begin
        rc_hi = 4'hf - round_i;
        x0 = state_in[319:256];
        x1 = state_in[255:192];
        x2 = state_in[191:128] ^ {56'h0, rc_hi, round_i};
        x3 = state_in[127:64];
        x4 = state_in[63:0];

        // bitsliced 5-bit s-box across all 64 columns
        a0 = x0 ^ x4;
        a2 = x2 ^ x1;
        a4 = x4 ^ x3;
        b0 = a0 ^ (~x1 & a2);
        b1 = x1 ^ (~a2 & x3);
        b2 = a2 ^ (~x3 & a4);
        b3 = x3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & x1);
        c0 = b0 ^ b4;
        c1 = b1 ^ b0;
        c2 = ~b2;
        c3 = b3 ^ b2;
        c4 = b4;

        state_out[319:256] = c0 ^ {c0[18:0], c0[63:19]} ^ {c0[27:0], c0[63:28]};
        state_out[255:192] = c1 ^ {c1[60:0], c1[63:61]} ^ {c1[38:0], c1[63:39]};
        state_out[191:128] = c2 ^ {c2[0],    c2[63:1]}  ^ {c2[5:0],  c2[63:6]};
        state_out[127:64]  = c3 ^ {c3[9:0],  c3[63:10]} ^ {c3[16:0], c3[63:17]};
        state_out[63:0]    = c4 ^ {c4[6:0],  c4[63:7]}  ^ {c4[40:0], c4[63:41]};
    end
endmodule

// state  | meaning
// IDLE   | waiting for start_i
// INIT   | p12 over key/nonce, key folded into S3/S4 on the last round
// AD     | p6 over the single AD block, domain bit into S4 on the last round
// WAIT_C | cipher_ready_o high, waiting for a ciphertext block
// DATA   | p6 between ciphertext blocks
// FINAL  | p12 after the last block, tag compare captured on the last round
// CHECK  | one-cycle done_o
module ascon_decrypt (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [63:0]  ad_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  cipher_i,
    input  logic         cipher_valid_i,
    input  logic         cipher_last_i,
    output logic         cipher_ready_o,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
`ifdef DECRYPT_ABORT_EN
   ,input  logic         abort_i
`endif
);
    localparam logic [63:0] IV  = 64'h80400C0600000000;
    localparam logic [63:0] PAD = 64'h8000000000000000;

    typedef enum logic [2:0] {IDLE, INIT, AD, WAIT_C, DATA, FINAL, CHECK} state_t;

    state_t        state_q, state_d;
    logic [319:0]  s_q;
    logic [319:0]  p_out;
    logic [127:0]  key_q;
    logic [127:0]  tag_q;
    logic [63:0]   ad_q;
    logic [3:0]    rnd_q;
    logic [63:0]   plain_q;
    logic          plain_vld_q;
    logic          tag_ok_q;
    logic          last_rnd;
    logic          abort;

`ifdef DECRYPT_ABORT_EN
    assign abort = abort_i && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign last_rnd = (rnd_q == 4'd11);

    ascon_p u_p (
        .state_in  (s_q),
        .round_i   (rnd_q),
        .state_out (p_out)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i)        state_d = INIT;
                INIT:    if (last_rnd)       state_d = AD;
                AD:      if (last_rnd)       state_d = WAIT_C;
                WAIT_C:  if (cipher_valid_i) state_d = cipher_last_i ? FINAL : DATA;
                DATA:    if (last_rnd)       state_d = WAIT_C;
                FINAL:   if (last_rnd)       state_d = CHECK;
                CHECK:                       state_d = IDLE;
                default:                     state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cipher_ready_o = (state_q == WAIT_C);
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == CHECK) && !abort;
        plain_o        = plain_q;
        plain_valid_o  = plain_vld_q;
        tag_ok_o       = tag_ok_q;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s_q         <= '0;
            key_q       <= '0;
            tag_q       <= '0;
            ad_q        <= '0;
            rnd_q       <= '0;
            plain_q     <= '0;
            plain_vld_q <= 1'b0;
            tag_ok_q    <= 1'b0;
        end else begin
            plain_vld_q <= 1'b0;
            if (abort) begin
                tag_ok_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            s_q      <= {IV, key_i, nonce_i};
                            key_q    <= key_i;
                            tag_q    <= tag_i;
                            ad_q     <= ad_i;
                            rnd_q    <= 4'd0;
                            tag_ok_q <= 1'b0;
                        end
                    end
                    INIT: begin
                        if (last_rnd) begin
                            // AD entry absorb shares the edge with the key fold
                            s_q   <= p_out ^ {ad_q, 128'h0, key_q};
                            rnd_q <= 4'd6;
                        end else begin
                            s_q   <= p_out;
                            rnd_q <= rnd_q + 4'd1;
                        end
                    end
                    AD: begin
                        s_q   <= last_rnd ? (p_out ^ 320'h1) : p_out;
                        rnd_q <= rnd_q + 4'd1;
                    end
                    WAIT_C: begin
                        if (cipher_valid_i) begin
                            plain_q     <= s_q[319:256] ^ cipher_i;
                            plain_vld_q <= 1'b1;
                            if (cipher_last_i) begin
                                s_q   <= {cipher_i ^ PAD, s_q[255:128] ^ key_q, s_q[127:0]};
                                rnd_q <= 4'd0;
                            end else begin
                                s_q[319:256] <= cipher_i;
                                rnd_q        <= 4'd6;
                            end
                        end
                    end
                    DATA: begin
                        s_q   <= p_out;
                        rnd_q <= rnd_q + 4'd1;
                    end
                    FINAL: begin
                        s_q   <= p_out;
                        rnd_q <= rnd_q + 4'd1;
                        if (last_rnd) begin
                            tag_ok_q <= ((p_out[127:0] ^ key_q) == tag_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
